// File: rtl/longest_match_grouper.sv
// longest_match_grouper: streaming greedy longest-prefix tokenizer
// over a runtime-loadable vocabulary held in registers.
module longest_match_grouper #(
    parameter int SYM_WIDTH   = 8,
    parameter int MAX_LEN     = 4,
    parameter int VOCAB_DEPTH = 16,
    parameter int ID_WIDTH    = $clog2(VOCAB_DEPTH),
    parameter int LEN_WIDTH   = $clog2(MAX_LEN + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cs,
    input  logic                         cfg_we,
    input  logic [ID_WIDTH-1:0]          cfg_addr,
    input  logic [LEN_WIDTH-1:0]         cfg_len,
    input  logic [MAX_LEN*SYM_WIDTH-1:0] cfg_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SYM_WIDTH-1:0]         in_sym,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ID_WIDTH-1:0]          out_id,
    output logic [LEN_WIDTH-1:0]         out_len,
    output logic                         out_miss,
    output logic [SYM_WIDTH-1:0]         out_sym,
    output logic                         out_last,
    output logic                         busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_SCAN,
        S_EMIT
    } state_t;

    localparam logic [LEN_WIDTH-1:0] FULL      = LEN_WIDTH'(MAX_LEN);
    localparam logic [ID_WIDTH-1:0]  LAST_ADDR = ID_WIDTH'(VOCAB_DEPTH - 1);

    state_t                       r_state;
    logic [LEN_WIDTH-1:0]         r_vlen  [VOCAB_DEPTH];
    logic [MAX_LEN*SYM_WIDTH-1:0] r_vdata [VOCAB_DEPTH];
    logic [SYM_WIDTH-1:0]         r_win   [MAX_LEN];
    logic [LEN_WIDTH-1:0]         r_cnt;
    logic                         r_last_seen;
    logic [ID_WIDTH-1:0]          r_addr;
    logic [ID_WIDTH-1:0]          r_best_id;
    logic [LEN_WIDTH-1:0]         r_best_len;
    logic [ID_WIDTH-1:0]          r_out_id;
    logic [LEN_WIDTH-1:0]         r_out_len;
    logic                         r_out_miss;
    logic                         r_out_last;
    logic [SYM_WIDTH-1:0]         r_out_sym;

    logic                         w_in_ready;
    logic                         w_accept;
    logic [LEN_WIDTH-1:0]         w_elen;
    logic [MAX_LEN*SYM_WIDTH-1:0] w_edata;
    logic                         w_match;
    logic                         w_done;
    logic [LEN_WIDTH-1:0]         w_fin_len;
    logic [ID_WIDTH-1:0]          w_fin_id;
    logic [LEN_WIDTH-1:0]         w_emit_len;
    logic [LEN_WIDTH-1:0]         w_rem;
    logic [SYM_WIDTH-1:0]         w_shift [MAX_LEN];

    assign w_in_ready = cs && !rst &&
        (r_state == S_IDLE ||
         (r_state == S_FILL && r_cnt < FULL && !r_last_seen));
    assign w_accept   = w_in_ready && in_valid;

    // Compare the entry at r_addr against the window and fold it into the best.
    always_comb begin
        w_elen  = r_vlen[r_addr];
        w_edata = r_vdata[r_addr];
        w_match = (w_elen != '0) && (w_elen <= r_cnt);
        for (int k = 0; k < MAX_LEN; k++) begin
            if (LEN_WIDTH'(k) < w_elen &&
                w_edata[k*SYM_WIDTH +: SYM_WIDTH] != r_win[k])
                w_match = 1'b0;
        end
        w_fin_len = r_best_len;
        w_fin_id  = r_best_id;
        if (w_match && w_elen > r_best_len) begin
            w_fin_len = w_elen;
            w_fin_id  = r_addr;
        end
        w_done     = (w_match && w_elen == r_cnt) || (r_addr == LAST_ADDR);
        w_emit_len = (w_fin_len == '0) ? LEN_WIDTH'(1) : w_fin_len;
    end

    always_comb begin
        w_rem = r_cnt - r_out_len;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_shift[i] = '0;
            for (int j = 0; j < MAX_LEN; j++) begin
                if (j == i + int'(r_out_len))
                    w_shift[i] = r_win[j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_last_seen <= 1'b0;
            r_addr      <= '0;
            r_best_id   <= '0;
            r_best_len  <= '0;
            r_out_id    <= '0;
            r_out_len   <= '0;
            r_out_miss  <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_sym   <= '0;
            for (int e = 0; e < VOCAB_DEPTH; e++) begin
                r_vlen[e]  <= '0;
                r_vdata[e] <= '0;
            end
            for (int i = 0; i < MAX_LEN; i++)
                r_win[i] <= '0;
        end else if (cs) begin
            unique case (r_state)
                S_IDLE: begin
                    if (cfg_we) begin
                        r_vlen[cfg_addr]  <= cfg_len;
                        r_vdata[cfg_addr] <= cfg_data;
                    end
                    if (w_accept) begin
                        r_win[0]    <= in_sym;
                        r_cnt       <= LEN_WIDTH'(1);
                        r_last_seen <= in_last;
                        r_state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (r_cnt == FULL || r_last_seen) begin
                        r_state    <= S_SCAN;
                        r_addr     <= '0;
                        r_best_len <= '0;
                        r_best_id  <= '0;
                    end else if (w_accept) begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (LEN_WIDTH'(i) == r_cnt)
                                r_win[i] <= in_sym;
                        end
                        r_cnt       <= r_cnt + LEN_WIDTH'(1);
                        r_last_seen <= in_last;
                    end
                end
                S_SCAN: begin
                    if (w_done) begin
                        r_out_miss <= (w_fin_len == '0);
                        r_out_len  <= w_emit_len;
                        r_out_id   <= (w_fin_len == '0) ? '0 : w_fin_id;
                        r_out_sym  <= r_win[0];
                        r_out_last <= r_last_seen && (w_emit_len == r_cnt);
                        r_state    <= S_EMIT;
                    end else begin
                        r_addr     <= r_addr + ID_WIDTH'(1);
                        r_best_len <= w_fin_len;
                        r_best_id  <= w_fin_id;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        for (int i = 0; i < MAX_LEN; i++)
                            r_win[i] <= w_shift[i];
                        r_cnt      <= w_rem;
                        r_out_id   <= '0;
                        r_out_len  <= '0;
                        r_out_miss <= 1'b0;
                        r_out_last <= 1'b0;
                        r_out_sym  <= '0;
                        if (r_last_seen && w_rem == '0) begin
                            r_state     <= S_IDLE;
                            r_last_seen <= 1'b0;
                        end else if (r_last_seen) begin
                            r_state    <= S_SCAN;
                            r_addr     <= '0;
                            r_best_len <= '0;
                            r_best_id  <= '0;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = cs && (r_state == S_EMIT);
    assign out_id    = r_out_id;
    assign out_len   = r_out_len;
    assign out_miss  = r_out_miss;
    assign out_sym   = r_out_sym;
    assign out_last  = r_out_last;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: doc/longest_match_grouper.md
Name: longest_match_grouper

Overview:
- Streaming greedy longest-match tokenizer: accepts a symbol stream, groups consecutive symbols into vocabulary tokens (longest prefix match, up to MAX_LEN symbols), emits one token ID per group.
- Generalises the fixed-width grouper/matcher pair: parametrised symbol width, token length and vocabulary depth; valid/ready streams replace internal input/output RAMs; unmatched symbols pass through as misses.
- Vocabulary is a runtime-loadable register array, written over a config port while idle.

Parameters:
- SYM_WIDTH, 8, bits per input symbol.
- MAX_LEN, 4, maximum symbols per vocabulary token and window depth (>=2).
- VOCAB_DEPTH, 16, number of vocabulary entries.
- ID_WIDTH, $clog2(VOCAB_DEPTH), token ID width.
- LEN_WIDTH, $clog2(MAX_LEN+1), length field width.

Ports:
- clk  in  1  clock; one clock domain, all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cs  in  1  chip select; low = freeze all state (no handshakes complete, ready/valid forced low).
- cfg_we  in  1  vocab write strobe; honoured only in IDLE.
- cfg_addr  in  ID_WIDTH  entry index.
- cfg_len  in  LEN_WIDTH  entry length; 0 = entry invalid.
- cfg_data  in  MAX_LEN*SYM_WIDTH  entry symbols, symbol 0 in LSBs.
- in_valid  in  1  input symbol valid.
- in_ready  out  1  block can accept a symbol.
- in_sym  in  SYM_WIDTH  input symbol.
- in_last  in  1  final symbol of stream.
- out_valid  out  1  token valid.
- out_ready  in  1  downstream accepts token.
- out_id  out  ID_WIDTH  matched entry index (0 on miss).
- out_len  out  LEN_WIDTH  symbols consumed by this token (1 on miss).
- out_miss  out  1  no entry matched; out_sym carries raw symbol.
- out_sym  out  SYM_WIDTH  window symbol 0 at emission.
- out_last  out  1  final token of stream.
- busy  out  1  not IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, window count 0, all vocab lengths 0, last_seen 0. Reset mid-operation aborts the stream; nothing partial is emitted.
- Window: MAX_LEN-entry shift buffer plus count (0..MAX_LEN). The last_seen flag is set when the in_last symbol is accepted.
- States:
  - IDLE: cfg writes allowed. in_ready=1. First accepted symbol goes to FILL.
  - FILL: in_ready=1 while count<MAX_LEN and !last_seen. Move to SCAN when count==MAX_LEN or last_seen.
  - SCAN: one vocab entry per cycle, addr 0 upward. Entry e matches if 1<=len_e<=count and symbols 0..len_e-1 equal window 0..len_e-1.
  - Best match: longest length wins; ties go to the lower index (strict > compare).
  - Early exit: SCAN ends the cycle after a match with len==count. Otherwise it ends after entry VOCAB_DEPTH-1. Max latency is VOCAB_DEPTH cycles.
  - EMIT: out_valid=1, fields stable until out_ready. On handshake: shift window left by out_len and reduce count by out_len.
  - After EMIT: if last_seen and count==0, go to IDLE and clear last_seen. Otherwise go to FILL, or straight to SCAN if last_seen.
- Miss: no entry matched gives out_miss=1, out_len=1, out_id=0, out_sym=window[0].
- out_last=1 on the EMIT where last_seen and out_len==count.
- Input never accepted in SCAN/EMIT (in_ready=0). in_valid with in_ready=0 has no effect.
- cfg_we outside IDLE is ignored, and vocab is unchanged. A cfg write and input accept in the same IDLE cycle are both honoured; the write is visible to that stream's first SCAN.
- cs low: all registers hold. in_ready/out_valid are driven 0 but the pending token is retained; it reasserts when cs returns high.

Test Plan:
- Vocab {0:"a",1:"ab",2:"abc",3:"b"}, MAX_LEN=4, stream "a b c a b"+last -> tokens (id2,len3), (id1,len2,out_last=1); then busy=0.
- Same vocab, stream "z a"+last -> (miss, sym='z', len1), (id0, len1, last). Stream "b" alone -> (id3, len1, last).
- Tie: entries 4 and 5 both "cd", stream "c d"+last -> out_id=4. Early exit: entry 2 "abc" with stream "abc"+last ends SCAN at cycle 3, not 16.
- Backpressure: out_ready=0 for 10 cycles during EMIT -> out_id/out_len/out_valid stable; in_ready=0; no symbol loss.
- cfg_we to entry 0 during SCAN -> ignored; readback behaviour shows old entry. cs=0 for 5 cycles mid-FILL -> state frozen, stream completes correctly after.
- Assert rst during SCAN -> all outputs 0 immediately, vocab lengths cleared; new vocab load plus stream then tokenizes correctly.
